wand_trace_recorder: RTL and testbench
======================================

Name: wand_trace_recorder

Overview:
- Player-side counterpart of the learn-mode wand animation: the animation *plays* a spell path over the 4x4 box grid; this block *captures* the path the player draws.
- Maps the player cursor (row/col) to a grid box, debounces box entry, and records the visited sequence in the same 16-nibble trace_order format.
- Checks the captured path live against the expected spell and reports pass/fail to the game FSM.

Parameters:
GRID_ROW0, 90, top pixel row of box row 0
GRID_COL0, 170, left pixel col of box col 0
BOX_SIZE, 100, box edge in pixels (boxes contiguous, 4x4)
DWELL_CYCLES, 500000, consecutive cycles cursor must stay in one box to register it
TIMEOUT_CYCLES, 150000000, max cycles between registered boxes while recording

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: arm a new capture
cursor_valid  in  1  cursor row/col valid this cycle
cursor_row  in  9  player cursor pixel row
cursor_col  in  10  player cursor pixel col
expected_order  in  64  expected path; nibble k = bits[4k+3:4k] = k-th box
expected_boxes  in  6  number of segments in expected path (boxes = segments+1)
recorded_order  out  64  captured path, same nibble packing; unused nibbles 0
recorded_count  out  5  boxes captured (0..16)
cur_box  out  4  box under cursor (registered)
in_grid  out  1  cursor valid and inside grid (registered)
busy  out  1  ARMED or RECORD
done  out  1  one-cycle pulse on entry to PASS or FAIL
pass  out  1  level, high in PASS
fail  out  1  level, high in FAIL

Behaviour:
- Reset (resetn=0 at posedge clk): state IDLE; recorded_order=0, recorded_count=0, cur_box=0, in_grid=0, busy=0, done=0, pass=0, fail=0; dwell and timeout counters 0.
- Box mapping: inside iff GRID_ROW0 <= row < GRID_ROW0+4*BOX_SIZE and same for col with GRID_COL0. box = 4*rowband + colband; band via compare chain, no divider. cur_box/in_grid registered 1 cycle after cursor sample; cur_box holds last value when outside.
- Dwell: counter clears when in_grid=0 or cur_box changes; otherwise increments, saturating. A box "registers" on the cycle the dwell count reaches DWELL_CYCLES-1, once per dwell; no re-registration until the cursor leaves that box.
- States:
  - IDLE: wait for start. Go to ARMED, clear recorded_*. If expected_boxes > 15, go to FAIL instead.
  - ARMED: the first registered box must equal expected nibble 0. If equal, store it at nibble 0, count=1, go to RECORD. If not, go to FAIL. No timeout in ARMED.
  - RECORD: a registered box equal to the last stored box is ignored. Otherwise it must be 4-adjacent to the last box: diff ±1 with the same rowband, or ±4. If it is not adjacent, or it differs from expected nibble[count], go to FAIL. If it matches, store it at nibble[count] and increment count. When count reaches expected_boxes+1 (updated value), go to PASS in the same cycle. The timeout counter resets on each registration; reaching TIMEOUT_CYCLES goes to FAIL.
  - PASS / FAIL: outputs held; recorded_* frozen. start returns to ARMED with a fresh capture.
- start in ARMED or RECORD: abort and restart immediately (clear, go to ARMED). start has priority over a same-cycle registration.
- done is high exactly one cycle on the transition into PASS or FAIL. busy=1 in ARMED/RECORD.
- expected_order/expected_boxes are sampled each cycle; the caller holds them stable while busy.
- expected_boxes=0: PASS on the first correct box.
- recorded_count never exceeds 16.
- cursor_valid=0 is treated as outside the grid.

Test Plan (DWELL_CYCLES=4, TIMEOUT_CYCLES=200):
- Reset then idle: all outputs 0.
- Row/col (90,170) gives cur_box=0, in_grid=1 next cycle. (489,569) gives box 15. (490,170) gives in_grid=0.
- Happy path: expected_order=64'h...6_5_1_0 (nibbles 0,1,5,6), expected_boxes=3, start. Cursor dwells 6 cycles in each of boxes 0,1,5,6. Result: pass=1, done pulse once, recorded_count=4, recorded_order=64'h0000_0000_0000_6510.
- Non-adjacent: same expected path, player goes 0 then 5 (diagonal). Result: fail=1 on registration of 5, recorded_count=1.
- Dwell glitch: cursor in box 1 for 3 cycles, back to 0, then 1 for 4 cycles. Box 1 registers exactly once, on the last of those 4 cycles.
- Timeout and restart: after box 0, no movement for 200 cycles gives fail=1. A start pulse mid-RECORD clears recorded_count to 0 and sets busy=1. expected_boxes=16 with start gives fail at once.

Source files
------------

// File: rtl/wand_trace_if.sv
// ============================================================================
// Module      : wand_trace_if
// Description : Bundle between the game FSM and the wand trace recorder.
//               The master modport belongs to the game side: it drives the
//               capture control, the cursor and the expected spell path.
//               The slave modport belongs to the recorder: it returns the
//               captured path, the cursor box and the pass/fail status.
// Signals     : start, cursor_valid, cursor_row[8:0], cursor_col[9:0],
//               expected_order[63:0], expected_boxes[5:0]  (game -> recorder)
//               recorded_order[63:0], recorded_count[4:0], cur_box[3:0],
//               in_grid, busy, done, pass, fail            (recorder -> game)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wand_trace_if;
  logic        start;
  logic        cursor_valid;
  logic [8:0]  cursor_row;
  logic [9:0]  cursor_col;
  logic [63:0] expected_order;
  logic [5:0]  expected_boxes;
  logic [63:0] recorded_order;
  logic [4:0]  recorded_count;
  logic [3:0]  cur_box;
  logic        in_grid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;

  modport master (
    output start, cursor_valid, cursor_row, cursor_col,
           expected_order, expected_boxes,
    input  recorded_order, recorded_count, cur_box, in_grid,
           busy, done, pass, fail
  );

  modport slave (
    input  start, cursor_valid, cursor_row, cursor_col,
           expected_order, expected_boxes,
    output recorded_order, recorded_count, cur_box, in_grid,
           busy, done, pass, fail
  );
endinterface

`default_nettype wire

// File: rtl/wand_trace_recorder.sv
// ============================================================================
// Module      : wand_trace_recorder
// Description : Captures the path the player draws over the 4x4 box grid.
//               The cursor is mapped to a box, box entry is debounced by a
//               dwell counter, and each registered box is checked live
//               against the expected spell path (nibble k = k-th box).
// Ports       : clk    - system clock
//               resetn - synchronous active-low reset
//               bus    - wand_trace_if.slave (control, cursor, expected
//                        path in; captured path, cursor box, status out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wand_trace_recorder #(
  parameter int GRID_ROW0      = 90,
  parameter int GRID_COL0      = 170,
  parameter int BOX_SIZE       = 100,
  parameter int DWELL_CYCLES   = 500000,
  parameter int TIMEOUT_CYCLES = 150000000
) (
  input  logic          clk,
  input  logic          resetn,
  wand_trace_if.slave   bus
);

  localparam int C_DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_DW_W-1:0] C_DW_LAST = C_DW_W'(DWELL_CYCLES - 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);

  // Band boundaries; coordinates are widened to 12 bits for the compares.
  localparam logic [11:0] C_ROW_B0 = 12'(GRID_ROW0);
  localparam logic [11:0] C_ROW_B1 = 12'(GRID_ROW0 + BOX_SIZE);
  localparam logic [11:0] C_ROW_B2 = 12'(GRID_ROW0 + 2 * BOX_SIZE);
  localparam logic [11:0] C_ROW_B3 = 12'(GRID_ROW0 + 3 * BOX_SIZE);
  localparam logic [11:0] C_ROW_B4 = 12'(GRID_ROW0 + 4 * BOX_SIZE);
  localparam logic [11:0] C_COL_B0 = 12'(GRID_COL0);
  localparam logic [11:0] C_COL_B1 = 12'(GRID_COL0 + BOX_SIZE);
  localparam logic [11:0] C_COL_B2 = 12'(GRID_COL0 + 2 * BOX_SIZE);
  localparam logic [11:0] C_COL_B3 = 12'(GRID_COL0 + 3 * BOX_SIZE);
  localparam logic [11:0] C_COL_B4 = 12'(GRID_COL0 + 4 * BOX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RECORD = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Cursor to box mapping
  // --------------------------------------------------------------------------
  logic [11:0] w_row;
  logic [11:0] w_col;
  logic [1:0]  w_row_band;
  logic [1:0]  w_col_band;
  logic        w_inside;

  assign w_row = {3'b000, bus.cursor_row};
  assign w_col = {2'b00, bus.cursor_col};

  assign w_inside = bus.cursor_valid &&
                    (w_row >= C_ROW_B0) && (w_row < C_ROW_B4) &&
                    (w_col >= C_COL_B0) && (w_col < C_COL_B4);

  always_comb begin
    w_row_band = 2'd3;
    if (w_row < C_ROW_B1)      w_row_band = 2'd0;
    else if (w_row < C_ROW_B2) w_row_band = 2'd1;
    else if (w_row < C_ROW_B3) w_row_band = 2'd2;
  end

  always_comb begin
    w_col_band = 2'd3;
    if (w_col < C_COL_B1)      w_col_band = 2'd0;
    else if (w_col < C_COL_B2) w_col_band = 2'd1;
    else if (w_col < C_COL_B3) w_col_band = 2'd2;
  end

  logic [3:0] r_cur_box;
  logic       r_in_grid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cur_box <= 4'd0;
      r_in_grid <= 1'b0;
    end else begin
      r_in_grid <= w_inside;
      // Outside the grid the last box is kept.
      if (w_inside) r_cur_box <= {w_row_band, w_col_band};
    end
  end

  // --------------------------------------------------------------------------
  // Dwell debounce: w_dwell_cur is the number of earlier consecutive cycles
  // the cursor has sat in the current box.  r_fired blocks a second
  // registration until the dwell is broken.
  // --------------------------------------------------------------------------
  logic [3:0]        r_prev_box;
  logic              r_prev_in;
  logic [C_DW_W-1:0] r_dwell;
  logic              r_fired;
  logic              w_same;
  logic [C_DW_W-1:0] w_dwell_cur;
  logic              w_at_last;
  logic              w_reg;

  assign w_same      = r_in_grid && r_prev_in && (r_cur_box == r_prev_box);
  assign w_dwell_cur = !w_same ? '0 :
                       (r_dwell == C_DW_LAST) ? r_dwell : r_dwell + C_DW_W'(1);
  assign w_at_last   = r_in_grid && (w_dwell_cur == C_DW_LAST);
  assign w_reg       = w_at_last && !r_fired;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prev_box <= 4'd0;
      r_prev_in  <= 1'b0;
      r_dwell    <= '0;
      r_fired    <= 1'b0;
    end else begin
      r_prev_box <= r_cur_box;
      r_prev_in  <= r_in_grid;
      r_dwell    <= w_dwell_cur;
      r_fired    <= w_at_last;
    end
  end

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  state_t            r_state, n_state;
  logic [63:0]       r_order, n_order;
  logic [4:0]        r_count, n_count;
  logic [3:0]        r_last,  n_last;
  logic [C_TO_W-1:0] r_tmo,   n_tmo;
  logic              r_done,  n_done;

  logic [3:0] w_exp_nib;
  logic [4:0] w_box5;
  logic [4:0] w_last5;
  logic       w_same_band;
  logic       w_adj;
  logic [4:0] w_count_inc;
  logic [6:0] w_goal;
  logic       w_too_long;

  assign w_exp_nib   = bus.expected_order[{r_count[3:0], 2'b00} +: 4];
  assign w_box5      = {1'b0, r_cur_box};
  assign w_last5     = {1'b0, r_last};
  assign w_same_band = (r_cur_box[3:2] == r_last[3:2]);
  // 5-bit sums keep +4 from wrapping row 3 back onto row 0.
  assign w_adj       = ((w_box5 == w_last5 + 5'd1) && w_same_band) ||
                       ((w_last5 == w_box5 + 5'd1) && w_same_band) ||
                       (w_box5 == w_last5 + 5'd4) ||
                       (w_last5 == w_box5 + 5'd4);
  assign w_count_inc = r_count + 5'd1;
  assign w_goal      = {1'b0, bus.expected_boxes} + 7'd1;
  assign w_too_long  = (bus.expected_boxes > 6'd15);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_order <= 64'd0;
      r_count <= 5'd0;
      r_last  <= 4'd0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= n_state;
      r_order <= n_order;
      r_count <= n_count;
      r_last  <= n_last;
      r_tmo   <= n_tmo;
      r_done  <= n_done;
    end
  end

  always_comb begin
    n_state = r_state;
    n_order = r_order;
    n_count = r_count;
    n_last  = r_last;
    n_tmo   = r_tmo;
    n_done  = 1'b0;

    if (bus.start) begin
      // A start always wins over a same-cycle registration.
      n_order = 64'd0;
      n_count = 5'd0;
      n_last  = 4'd0;
      n_tmo   = '0;
      if (w_too_long) begin
        n_state = S_FAIL;
        n_done  = 1'b1;
      end else begin
        n_state = S_ARMED;
      end
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_reg) begin
            if (r_cur_box == w_exp_nib) begin
              n_order[3:0] = r_cur_box;
              n_count      = 5'd1;
              n_last       = r_cur_box;
              n_tmo        = '0;
              if (w_goal == 7'd1) begin
                n_state = S_PASS;
                n_done  = 1'b1;
              end else begin
                n_state = S_RECORD;
              end
            end else begin
              n_state = S_FAIL;
              n_done  = 1'b1;
            end
          end
        end

        S_RECORD: begin
          if (w_reg) begin
            n_tmo = '0;
            // Re-entering the last stored box is not a new segment.
            if (r_cur_box != r_last) begin
              if (!w_adj || (r_cur_box != w_exp_nib)) begin
                n_state = S_FAIL;
                n_done  = 1'b1;
              end else begin
                n_order[{r_count[3:0], 2'b00} +: 4] = r_cur_box;
                n_count = w_count_inc;
                n_last  = r_cur_box;
                if ({2'b00, w_count_inc} == w_goal) begin
                  n_state = S_PASS;
                  n_done  = 1'b1;
                end
              end
            end
          end else if (r_tmo == C_TO_LAST) begin
            n_state = S_FAIL;
            n_done  = 1'b1;
          end else begin
            n_tmo = r_tmo + C_TO_W'(1);
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign bus.recorded_order = r_order;
  assign bus.recorded_count = r_count;
  assign bus.cur_box        = r_cur_box;
  assign bus.in_grid        = r_in_grid;
  assign bus.busy           = (r_state == S_ARMED) || (r_state == S_RECORD);
  assign bus.done           = r_done;
  assign bus.pass           = (r_state == S_PASS);
  assign bus.fail           = (r_state == S_FAIL);

endmodule

`default_nettype wire

// File: tb/tb_wand_trace_recorder.sv
// ============================================================================
// Module      : tb_wand_trace_recorder
// Description : Self-checking bench for wand_trace_recorder.  Box mapping is
//               table driven; capture scenarios are hand-written sequences
//               whose final results are queued at start and popped when the
//               recorder pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wand_trace_recorder;
  localparam int DW = 4;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wand_trace_if bus_if ();

  wand_trace_recorder #(
    .GRID_ROW0     (90),
    .GRID_COL0     (170),
    .BOX_SIZE      (100),
    .DWELL_CYCLES  (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [4:0]  count;
    logic [63:0] order;
  } result_t;

  typedef struct {
    logic       valid;
    logic [8:0] row;
    logic [9:0] col;
    logic       exp_in;
    logic [3:0] exp_box;
  } map_vec_t;

  typedef struct {
    logic       in_grid;
    logic [3:0] box;
  } map_exp_t;

  result_t  sb_q[$];
  map_exp_t map_q[$];
  map_vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Completion scoreboard: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    result_t e;
    if (resetn && bus_if.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done=1, want no completion pending");
      end else begin
        e = sb_q.pop_front();
        check("done_pass",  64'(bus_if.pass), 64'(e.pass));
        check("done_fail",  64'(bus_if.fail), 64'(e.fail));
        check("done_count", 64'(bus_if.recorded_count), 64'(e.count));
        check("done_order", bus_if.recorded_order, e.order);
      end
    end
  end

  task automatic cursor_at(input int b, input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.cursor_valid = 1'b1;
      bus_if.cursor_row   = 9'(90 + 100 * (b / 4) + 50);
      bus_if.cursor_col   = 10'(170 + 100 * (b % 4) + 50);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.cursor_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  function automatic result_t mk(input logic p, input logic f, input logic [4:0] c,
                                 input logic [63:0] o);
    result_t r;
    r.pass = p; r.fail = f; r.count = c; r.order = o;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    map_exp_t me;

    vecs[0]  = '{1'b1, 9'd90,  10'd170, 1'b1, 4'd0};
    vecs[1]  = '{1'b1, 9'd489, 10'd569, 1'b1, 4'd15};
    vecs[2]  = '{1'b1, 9'd490, 10'd170, 1'b0, 4'd15};
    vecs[3]  = '{1'b1, 9'd89,  10'd300, 1'b0, 4'd15};
    vecs[4]  = '{1'b1, 9'd189, 10'd269, 1'b1, 4'd0};
    vecs[5]  = '{1'b1, 9'd190, 10'd270, 1'b1, 4'd5};
    vecs[6]  = '{1'b1, 9'd300, 10'd470, 1'b1, 4'd11};
    vecs[7]  = '{1'b0, 9'd200, 10'd200, 1'b0, 4'd11};
    vecs[8]  = '{1'b1, 9'd90,  10'd569, 1'b1, 4'd3};
    vecs[9]  = '{1'b1, 9'd489, 10'd170, 1'b1, 4'd12};
    vecs[10] = '{1'b1, 9'd250, 10'd569, 1'b1, 4'd7};
    vecs[11] = '{1'b1, 9'd90,  10'd570, 1'b0, 4'd7};

    bus_if.start          = 1'b0;
    bus_if.cursor_valid   = 1'b0;
    bus_if.cursor_row     = 9'd0;
    bus_if.cursor_col     = 10'd0;
    bus_if.expected_order = 64'd0;
    bus_if.expected_boxes = 6'd0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_order", bus_if.recorded_order, 64'd0);
    check("rst_count", 64'(bus_if.recorded_count), 64'd0);
    check("rst_cur_box", 64'(bus_if.cur_box), 64'd0);
    check("rst_in_grid", 64'(bus_if.in_grid), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_pass", 64'(bus_if.pass), 64'd0);
    check("rst_fail", 64'(bus_if.fail), 64'd0);

    // Box mapping table: result appears one cycle after the cursor sample.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (map_q.size() > 0) begin
        me = map_q.pop_front();
        check("map_in_grid", 64'(bus_if.in_grid), 64'(me.in_grid));
        check("map_cur_box", 64'(bus_if.cur_box), 64'(me.box));
      end
      bus_if.cursor_valid = vecs[i].valid;
      bus_if.cursor_row   = vecs[i].row;
      bus_if.cursor_col   = vecs[i].col;
      me.in_grid = vecs[i].exp_in;
      me.box     = vecs[i].exp_box;
      map_q.push_back(me);
    end
    @(negedge clk);
    me = map_q.pop_front();
    check("map_in_grid", 64'(bus_if.in_grid), 64'(me.in_grid));
    check("map_cur_box", 64'(bus_if.cur_box), 64'(me.box));
    idle(4);

    // Happy path 0 -> 1 -> 5 -> 6.
    bus_if.expected_order = 64'h6510;
    bus_if.expected_boxes = 6'd3;
    done_cnt = 0;
    sb_q.push_back(mk(1'b1, 1'b0, 5'd4, 64'h6510));
    pulse_start();
    check("happy_busy", 64'(bus_if.busy), 64'd1);
    cursor_at(0, 6);
    cursor_at(1, 6);
    cursor_at(5, 6);
    cursor_at(6, 6);
    @(negedge clk);
    check("happy_pass", 64'(bus_if.pass), 64'd1);
    check("happy_busy_end", 64'(bus_if.busy), 64'd0);
    idle(3);
    check("happy_pass_held", 64'(bus_if.pass), 64'd1);
    check("happy_order_held", bus_if.recorded_order, 64'h6510);
    check("happy_done_once", 64'(done_cnt), 64'd1);

    // Diagonal move 0 -> 5 fails on registration of 5.
    idle(4);
    sb_q.push_back(mk(1'b0, 1'b1, 5'd1, 64'h0));
    pulse_start();
    cursor_at(0, 6);
    check("diag_count_mid", 64'(bus_if.recorded_count), 64'd1);
    cursor_at(5, 6);
    @(negedge clk);
    check("diag_fail", 64'(bus_if.fail), 64'd1);
    check("diag_count", 64'(bus_if.recorded_count), 64'd1);

    // Dwell glitch: 3 cycles in 1 do not register; 4 do, exactly once.
    idle(4);
    sb_q.push_back(mk(1'b1, 1'b0, 5'd4, 64'h6510));
    pulse_start();
    cursor_at(0, 6);
    cursor_at(1, 3);
    cursor_at(0, 6);
    check("glitch_count_short", 64'(bus_if.recorded_count), 64'd1);
    cursor_at(1, 4);
    @(negedge clk);
    check("glitch_not_yet", 64'(bus_if.recorded_count), 64'd1);
    @(negedge clk);
    check("glitch_reg", 64'(bus_if.recorded_count), 64'd2);
    check("glitch_order", bus_if.recorded_order, 64'h10);
    cursor_at(1, 4);
    check("glitch_once", 64'(bus_if.recorded_count), 64'd2);
    cursor_at(5, 6);
    cursor_at(6, 6);
    @(negedge clk);
    check("glitch_pass", 64'(bus_if.pass), 64'd1);

    // Timeout: fail lands exactly TO cycles after the last registration.
    idle(4);
    sb_q.push_back(mk(1'b0, 1'b1, 5'd1, 64'h0));
    pulse_start();
    cursor_at(0, 6);
    repeat (TO - 1) @(negedge clk);
    check("tmo_not_yet", 64'(bus_if.fail), 64'd0);
    check("tmo_busy", 64'(bus_if.busy), 64'd1);
    @(negedge clk);
    check("tmo_fail", 64'(bus_if.fail), 64'd1);

    // Restart in the middle of a capture.
    idle(4);
    pulse_start();
    cursor_at(0, 6);
    check("restart_pre", 64'(bus_if.recorded_count), 64'd1);
    pulse_start();
    check("restart_count", 64'(bus_if.recorded_count), 64'd0);
    check("restart_busy", 64'(bus_if.busy), 64'd1);
    check("restart_order", bus_if.recorded_order, 64'h0);

    // Single-box spell: expected_boxes = 0 passes on the first correct box.
    idle(4);
    bus_if.expected_order = 64'h5;
    bus_if.expected_boxes = 6'd0;
    sb_q.push_back(mk(1'b1, 1'b0, 5'd1, 64'h5));
    pulse_start();
    cursor_at(5, 6);
    @(negedge clk);
    check("one_box_pass", 64'(bus_if.pass), 64'd1);
    check("one_box_order", bus_if.recorded_order, 64'h5);

    // Oversized spell from IDLE fails at once.
    idle(2);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus_if.expected_boxes = 6'd16;
    sb_q.push_back(mk(1'b0, 1'b1, 5'd0, 64'h0));
    pulse_start();
    check("long_fail", 64'(bus_if.fail), 64'd1);
    check("long_busy", 64'(bus_if.busy), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
